cfg_chain_ctrl: RTL
===================

CFG_CHAIN_CTRL -- requirements
Module: cfg_chain_ctrl

Interface
REQ-001 Parameter NUM_CHAINS, default 4, number of independent serial configuration chains (1..16).
REQ-002 Parameter BASE_ADDR, default 32'h3000_0000, byte address of register 0; registers DATA=+0x0, CTRL=+0x4, STATUS=+0x8.
REQ-003 clk  in  1  clock; all state on rising edge except sout retiming (REQ-014).
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 valid, wen  in  1 each  bus request and write qualifier.
REQ-006 wb_addr, wdata  in  32 each  bus address and write data.
REQ-007 ready  out  1  one-cycle bus acknowledge.
REQ-008 rdata  out  32  read data, valid while ready=1.
REQ-009 sin  in  NUM_CHAINS  serial return data from each chain tail.
REQ-010 sout, sen, latch  out  NUM_CHAINS each  serial data, shift enable, update strobe per chain.
REQ-011 busy  out  1  high whenever FSM not IDLE.

Function
REQ-012 ready SHALL pulse high exactly one cycle after any valid request with ready low, for any address; valid held after ready SHALL not produce a second ack until ready has been low one cycle.
REQ-013 Unmapped address: write ignored, rdata=0, still acked.
REQ-014 sout[sel] SHALL be driven from a flop updated on falling clk edge with tx[31]; unselected sout bits 0.
REQ-015 DATA write loads tx[31:0]; DATA read returns rx[31:0].
REQ-016 CTRL fields: [4:0] nbits-1 (1..32 bits), [11:8] chain select, [30] latch_after, [31] start; CTRL read returns last written value with bit31 reads 0.
REQ-017 STATUS read: [0] busy, [1] done (sticky), [2] err (sticky); write 1 to bit1/bit2 clears it.
REQ-018 FSM states IDLE, SHIFT, LATCH.
REQ-019 IDLE->SHIFT on CTRL write with start=1 and select<NUM_CHAINS, in the ack cycle; counter loaded with nbits-1.
REQ-020 SHIFT: each cycle sen[sel]=1, tx<=tx<<1, rx<={rx[30:0],sin[sel]}, counter decrements; exactly nbits cycles.
REQ-021 SHIFT exit at counter 0: to LATCH if latch_after else IDLE.
REQ-022 LATCH: latch[sel]=1 for one cycle, then IDLE.
REQ-023 Entry to IDLE from SHIFT/LATCH SHALL set done same edge; done and a new start in same cycle: start wins, done still set.
REQ-024 Any DATA/CTRL write while busy, or start with select>=NUM_CHAINS: acked, ignored, err set.
REQ-025 Only selected chain's sen/latch ever asserted; all others 0.

Reset
REQ-026 Reset SHALL force IDLE, tx, rx, CTRL, done, err, counter to 0; ready, busy, sen, latch, sout, rdata to 0 on next edge (sout on following falling edge), aborting any shift mid-operation with no latch pulse.

Structure
REQ-027 Shared package cfg_chain_pkg holds register offsets, CTRL/STATUS bit positions, FSM state encoding.
REQ-028 One sub-module cfg_chain_shifter (tx/rx registers, bit counter, sout retiming); bus decode and FSM in top.

Verification
REQ-029 Write DATA=0xA5000000, CTRL=0xC0000107 (8 bits, chain1, latch) -> sen[1] high 8 cycles, sout[1] sequence 1,0,1,0,0,1,0,1, one latch[1] pulse, done=1.
REQ-030 Loop sout[2]->sin[2] with one-cycle delay, shift 32 bits 0xDEADBEEF on chain2 -> DATA read = 0xDEADBEEF>>1 with bit31 = prior sout (0).
REQ-031 CTRL write select=5 with NUM_CHAINS=4 -> no sen activity, STATUS=0x4; write 0x4 to STATUS -> reads 0x0.
REQ-032 DATA write during SHIFT -> ack in one cycle, tx stream unchanged, err=1.
REQ-033 Assert reset at shift cycle 3 of 16 -> busy, sen, latch 0 next edge, no latch pulse, all registers read 0.
REQ-034 Read address BASE+0xC -> ready after one cycle, rdata=0; valid held 3 cycles -> ready pattern 0,1,0,1.

Source files
------------

// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the serial configuration chain controller:
// register offsets, CTRL/STATUS field positions and FSM state encoding.
package cfg_chain_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0008;

    localparam int CTRL_NBITS_LSB = 0;
    localparam int CTRL_NBITS_MSB = 4;
    localparam int CTRL_SEL_LSB   = 8;
    localparam int CTRL_SEL_MSB   = 11;
    localparam int CTRL_LATCH_BIT = 30;
    localparam int CTRL_START_BIT = 31;

    localparam int ST_BUSY_BIT = 0;
    localparam int ST_DONE_BIT = 1;
    localparam int ST_ERR_BIT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } chain_state_e;

    // CTRL readback hides the self-clearing start bit.
    function automatic logic [31:0] ctrl_readback(input logic [31:0] ctrl);
        logic [31:0] v;
        v = ctrl;
        v[CTRL_START_BIT] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/cfg_chain_shifter.sv
// Datapath for one active chain: transmit/receive shift registers, bit
// counter, and the falling-edge retiming flop that launches serial data.
module cfg_chain_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_tx,
    input  logic [31:0] load_data,
    input  logic        start_cnt,
    input  logic [4:0]  cnt_init,
    input  logic        shift_en,
    input  logic        sin_bit,
    output logic [31:0] rx,
    output logic        cnt_zero,
    output logic        sout_bit
);

    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sout_q, sout_d;

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (reset) begin
            tx_d  = '0;
            rx_d  = '0;
            cnt_d = '0;
        end else begin
            if (load_tx) begin
                tx_d = load_data;
            end
            if (start_cnt) begin
                cnt_d = cnt_init;
            end
            if (shift_en) begin
                tx_d = {tx_q[30:0], 1'b0};
                rx_d = {rx_q[30:0], sin_bit};
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        tx_q  <= tx_d;
        rx_q  <= rx_d;
        cnt_q <= cnt_d;
    end

    // Launch on the falling edge so the chain sees half a cycle of setup
    // ahead of the rising edge that shifts it.
    assign sout_d = reset ? 1'b0 : tx_q[31];

    always_ff @(negedge clk) begin
        sout_q <= sout_d;
    end

    assign rx       = rx_q;
    assign cnt_zero = (cnt_q == 5'd0);
    assign sout_bit = sout_q;

endmodule

// File: rtl/cfg_chain_ctrl.sv
// Bus-mapped controller for NUM_CHAINS serial configuration chains: register
// decode, shift/latch sequencing and per-chain output steering.
module cfg_chain_ctrl
    import cfg_chain_pkg::*;
#(
    parameter int          NUM_CHAINS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  wen,
    input  logic [31:0]           wb_addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic [31:0]           rdata,
    input  logic [NUM_CHAINS-1:0] sin,
    output logic [NUM_CHAINS-1:0] sout,
    output logic [NUM_CHAINS-1:0] sen,
    output logic [NUM_CHAINS-1:0] latch,
    output logic                  busy
);

    localparam logic [4:0] NUM_CHAINS_W = 5'(NUM_CHAINS);

    chain_state_e          state_q, state_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           ctrl_q, ctrl_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [NUM_CHAINS-1:0] sen_q, sen_d;
    logic [NUM_CHAINS-1:0] latch_q, latch_d;

    logic [NUM_CHAINS-1:0] sel_q_hot, sel_d_hot, sin_masked;
    logic [31:0]           off, status_word, rx;
    logic                  accept, is_busy, hit_data, hit_ctrl, hit_status;
    logic                  wr_data, wr_ctrl, wr_status, sel_ok, start_req;
    logic                  blocked, bad_sel, go, ctrl_we, load_tx;
    logic                  shift_en, sin_bit, cnt_zero, sout_bit;

    // A request is taken only while ready is low, so a held valid is
    // acknowledged on alternate cycles.
    assign accept     = valid && !ready_q;
    assign off        = wb_addr - BASE_ADDR;
    assign hit_data   = (off == OFF_DATA);
    assign hit_ctrl   = (off == OFF_CTRL);
    assign hit_status = (off == OFF_STATUS);
    assign is_busy    = (state_q != ST_IDLE);

    assign wr_data   = accept && wen && hit_data;
    assign wr_ctrl   = accept && wen && hit_ctrl;
    assign wr_status = accept && wen && hit_status;
    assign sel_ok    = ({1'b0, wdata[CTRL_SEL_MSB:CTRL_SEL_LSB]} < NUM_CHAINS_W);
    assign start_req = wdata[CTRL_START_BIT];

    assign blocked = (wr_data || wr_ctrl) && is_busy;
    assign bad_sel = wr_ctrl && !is_busy && start_req && !sel_ok;
    assign go      = wr_ctrl && !is_busy && start_req && sel_ok;
    assign ctrl_we = wr_ctrl && !is_busy && !(start_req && !sel_ok);
    assign load_tx = wr_data && !is_busy;

    assign shift_en = (state_q == ST_SHIFT);

    always_comb begin
        status_word = '0;
        status_word[ST_BUSY_BIT] = is_busy;
        status_word[ST_DONE_BIT] = done_q;
        status_word[ST_ERR_BIT]  = err_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
            assign sel_q_hot[gi]  = (ctrl_q[CTRL_SEL_MSB:CTRL_SEL_LSB] == 4'(gi));
            assign sel_d_hot[gi]  = (ctrl_d[CTRL_SEL_MSB:CTRL_SEL_LSB] == 4'(gi));
            assign sin_masked[gi] = sin[gi] && sel_q_hot[gi];
            assign sout[gi]       = sout_bit && sel_q_hot[gi];
        end
    endgenerate

    assign sin_bit = |sin_masked;

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = '0;
        ctrl_d  = ctrl_q;
        done_d  = done_q;
        err_d   = err_q;
        busy_d  = 1'b0;
        sen_d   = '0;
        latch_d = '0;
        if (reset) begin
            state_d = ST_IDLE;
            ctrl_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            ready_d = accept;
            if (accept && !wen) begin
                if (hit_data) begin
                    rdata_d = rx;
                end else if (hit_ctrl) begin
                    rdata_d = ctrl_readback(ctrl_q);
                end else if (hit_status) begin
                    rdata_d = status_word;
                end
            end

            if (wr_status) begin
                if (wdata[ST_DONE_BIT]) done_d = 1'b0;
                if (wdata[ST_ERR_BIT])  err_d  = 1'b0;
            end
            if (blocked || bad_sel) begin
                err_d = 1'b1;
            end
            if (ctrl_we) begin
                ctrl_d = wdata;
            end

            // Completion sets done after any clear so a same-cycle clear loses.
            case (state_q)
                ST_IDLE: begin
                    if (go) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_zero) begin
                        if (ctrl_q[CTRL_LATCH_BIT]) begin
                            state_d = ST_LATCH;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase

            busy_d  = (state_d != ST_IDLE);
            sen_d   = (state_d == ST_SHIFT) ? sel_d_hot : '0;
            latch_d = (state_d == ST_LATCH) ? sel_d_hot : '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ready_q <= ready_d;
        rdata_q <= rdata_d;
        ctrl_q  <= ctrl_d;
        done_q  <= done_d;
        err_q   <= err_d;
        busy_q  <= busy_d;
        sen_q   <= sen_d;
        latch_q <= latch_d;
    end

    cfg_chain_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_tx   (load_tx),
        .load_data (wdata),
        .start_cnt (go),
        .cnt_init  (wdata[CTRL_NBITS_MSB:CTRL_NBITS_LSB]),
        .shift_en  (shift_en),
        .sin_bit   (sin_bit),
        .rx        (rx),
        .cnt_zero  (cnt_zero),
        .sout_bit  (sout_bit)
    );

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign sen   = sen_q;
    assign latch = latch_q;

endmodule
